ps2_kbd_events: RTL
===================

# ps2_kbd_events

Scancode sequencer that sits directly behind the PS/2 byte receiver. It takes raw set-2 bytes (with strobe and error pulses) and collapses prefix sequences (E0, F0, E0 F0, the 8-byte E1 Pause sequence) into single key events. Completed events are buffered in a small FIFO drained via a valid/ready handshake. Keyboard status bytes are decoded into one-cycle pulses, and a watchdog clears half-received sequences.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥ 2
- TIMEOUT_CYCLES, 2500000, idle clocks after which a partial prefix sequence is abandoned; ≥ 2
- clk  input  1  system clock, same domain as the byte receiver
- reset  input  1  synchronous, active-high
- ps2_code  input  8  received byte, valid when ps2_strobe=1
- ps2_strobe  input  1  one-cycle pulse, byte received with good parity/stop
- ps2_err  input  1  one-cycle pulse, framing/parity error
- ev_code  output  8  key scancode (prefixes removed)
- ev_extended  output  1  key had E0 prefix (also set for Pause)
- ev_released  output  1  key-up event
- ev_valid  output  1  FIFO head valid
- ev_ready  input  1  consumer accepts head when ev_valid & ev_ready
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- overflow_clr  input  1  clears overflow
- bat_ok, bat_fail, ack, resend, kbd_overrun  output  1 each  one-cycle status pulses for bytes AA, FC, FA, FE, 00/FF
- err_count  output  8  saturating count of ps2_err pulses

## Operation
- FSM states: IDLE, E0, F0, E0F0, PAUSE. Events are handled on ps2_strobe only; other cycles are idle except for the timeout.
- IDLE:
  - E0 → E0; F0 → F0; E1 → PAUSE with pause_cnt=1.
  - AA/FC/FA/FE/00/FF → corresponding status pulse, no event.
  - Any other byte b → push {rel=0, ext=0, b}.
- E0: F0 → E0F0; 12 or 59 (fake-shift) → discard, go to IDLE; other b → push {0,1,b}, go to IDLE.
- F0: b → push {1,0,b}, go to IDLE.
- E0F0: 12 or 59 → discard, go to IDLE; other b → push {1,1,b}, go to IDLE.
- PAUSE: bytes are discarded and pause_cnt increments. The byte that makes pause_cnt reach 8 pushes a single event {0,1,77}, then the FSM goes to IDLE. Byte contents are not checked.
- Status bytes arriving outside IDLE are treated as ordinary data bytes for that state (no pulse).
- ps2_err:
  - Always: err_count += 1, saturating at FF.
  - If the FSM is not in IDLE, it goes to IDLE and the partial sequence is discarded, with no event.
  - If ps2_err and ps2_strobe occur in the same cycle, the error wins and the byte is ignored.
- Timeout:
  - A counter clears on every strobe/err and increments while the FSM is not in IDLE.
  - On reaching TIMEOUT_CYCLES−1, the FSM goes to IDLE and the counter clears.
  - A strobe in the same cycle takes precedence over the timeout.
- FIFO is show-ahead: the head is presented on ev_* while ev_valid=1.
  - A push when full is dropped and sets overflow, unless a pop occurs in the same cycle; then the push is accepted.
  - Simultaneous push and pop when empty: the pushed event appears next cycle and the pop is a no-op.
- overflow:
  - overflow_clr clears it.
  - If a set and a clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - FSM=IDLE, FIFO empty, ev_valid=0, ev_code=00, ev_extended=0, ev_released=0.
  - overflow=0, all status pulses 0, err_count=00, timeout counter 0, pause_cnt 0.
- Reset mid-sequence or with a non-empty FIFO discards everything.
- Latency: a strobe sampled at edge k that completes an event writes the FIFO at edge k. With the FIFO previously empty, ev_valid=1 in the cycle after edge k.
- Status pulses are high for exactly the cycle after the strobe edge.
- Throughput: one event per clock in and out. The byte stream is far slower than this, so overflow occurs only if the consumer stalls.
- ev_* are stable while ev_valid=1 and ev_ready=0.

## Test plan
- Bytes 1C, F0 1C → events {0,0,1C} then {1,0,1C}; ev_valid rises one cycle after the 1C strobe.
- E0 74, E0 F0 74, and Print-Screen make E0 12 E0 7C → events {0,1,74}, {1,1,74}, {0,1,7C}. The fake-shift 12 produces no event.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event {0,1,77}; following byte 1C → {0,0,1C}.
- Bytes AA, FA, FE, FC, 00 in IDLE → one pulse each on bat_ok, ack, resend, bat_fail, kbd_overrun, and no events. E0 then ps2_err then 1C → err_count=1 and event {0,0,1C}.
- With TIMEOUT_CYCLES=16: F0, then 16 idle cycles, then 1C → event {0,0,1C} (not a release).
- With ev_ready=0, push FIFO_DEPTH+1 makes → the first 8 events are retained and overflow=1. Then ev_ready=1 with a simultaneous push while full → accepted, no new drop. overflow_clr → overflow=0.

Source files
------------

// File: rtl/ps2_kbd_events_if.sv
// Key-event handshake between the scancode sequencer (master) and its consumer (slave).
// The master presents the FIFO head on ev_*; the slave accepts it with ev_ready.
interface ps2_kbd_events_if;
  logic [7:0] ev_code;
  logic       ev_extended;
  logic       ev_released;
  logic       ev_valid;
  logic       ev_ready;

  modport master (output ev_code, ev_extended, ev_released, ev_valid, input ev_ready);
  modport slave  (input ev_code, ev_extended, ev_released, ev_valid, output ev_ready);
endinterface

// File: rtl/ps2_kbd_events.sv
// PS/2 set-2 scancode sequencer: folds E0/F0/E0F0/E1-Pause prefixes into single key events,
// buffers them in a show-ahead FIFO, and decodes keyboard status bytes into pulses.
module ps2_kbd_events #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             ps2_code,
  input  logic                   ps2_strobe,
  input  logic                   ps2_err,
  ps2_kbd_events_if.master       ev,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic                   bat_ok,
  output logic                   bat_fail,
  output logic                   ack,
  output logic                   resend,
  output logic                   kbd_overrun,
  output logic [7:0]             err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_E0    = 3'd1;
  localparam logic [2:0] ST_F0    = 3'd2;
  localparam logic [2:0] ST_E0F0  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  typedef struct packed {
    logic       released;
    logic       extended;
    logic [7:0] code;
  } ev_t;

  logic [2:0]    state, state_nxt;
  logic [2:0]    pause_cnt, pause_nxt;
  logic [TW-1:0] to_cnt;
  logic [4:0]    pulse_nxt;
  logic          push;
  ev_t           push_ev;

  ev_t           mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push_ok, drop;
  ev_t           head;

  // E0 12 / E0 59 are the fake-shift bytes wrapped around some extended keys.
  logic fake_shift;
  assign fake_shift = (ps2_code == 8'h12) || (ps2_code == 8'h59);

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    state_nxt = state;
    pause_nxt = pause_cnt;
    pulse_nxt = '0;
    push      = 1'b0;
    push_ev   = '0;
    if (ps2_err) begin
      state_nxt = ST_IDLE;
      pause_nxt = '0;
    end else if (ps2_strobe) begin
      case (state)
        ST_IDLE: begin
          case (ps2_code)
            8'hE0:        state_nxt = ST_E0;
            8'hF0:        state_nxt = ST_F0;
            8'hE1: begin
              state_nxt = ST_PAUSE;
              pause_nxt = 3'd1;
            end
            8'hAA:        pulse_nxt[4] = 1'b1;
            8'hFC:        pulse_nxt[3] = 1'b1;
            8'hFA:        pulse_nxt[2] = 1'b1;
            8'hFE:        pulse_nxt[1] = 1'b1;
            8'h00, 8'hFF: pulse_nxt[0] = 1'b1;
            default: begin
              push    = 1'b1;
              push_ev = '{released: 1'b0, extended: 1'b0, code: ps2_code};
            end
          endcase
        end
        ST_E0: begin
          state_nxt = (ps2_code == 8'hF0) ? ST_E0F0 : ST_IDLE;
          if (ps2_code != 8'hF0 && !fake_shift) begin
            push    = 1'b1;
            push_ev = '{released: 1'b0, extended: 1'b1, code: ps2_code};
          end
        end
        ST_F0: begin
          state_nxt = ST_IDLE;
          push      = 1'b1;
          push_ev   = '{released: 1'b1, extended: 1'b0, code: ps2_code};
        end
        ST_E0F0: begin
          state_nxt = ST_IDLE;
          if (!fake_shift) begin
            push    = 1'b1;
            push_ev = '{released: 1'b1, extended: 1'b1, code: ps2_code};
          end
        end
        ST_PAUSE: begin
          // Pause is eight bytes long; the eighth one emits the single E0-77 event.
          if (pause_cnt == 3'd7) begin
            state_nxt = ST_IDLE;
            pause_nxt = '0;
            push      = 1'b1;
            push_ev   = '{released: 1'b0, extended: 1'b1, code: 8'h77};
          end else begin
            pause_nxt = pause_cnt + 3'd1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
      state_nxt = ST_IDLE;
      pause_nxt = '0;
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && ev.ev_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= ST_IDLE;
      pause_cnt   <= '0;
      to_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      err_count   <= '0;
      bat_ok      <= 1'b0;
      bat_fail    <= 1'b0;
      ack         <= 1'b0;
      resend      <= 1'b0;
      kbd_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      pause_cnt <= pause_nxt;
      {bat_ok, bat_fail, ack, resend, kbd_overrun} <= pulse_nxt;

      if (ps2_strobe || ps2_err)
        to_cnt <= '0;
      else if (state != ST_IDLE && to_cnt != TO_LAST)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;

      if (ps2_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      if (drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; validity comes from the pointers, and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr[AW-1:0]] <= push_ev;
  end

  assign head           = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign ev.ev_valid    = !empty;
  assign ev.ev_code     = head.code;
  assign ev.ev_extended = head.extended;
  assign ev.ev_released = head.released;

endmodule
